// File: rtl/branch_resolver.sv
// -----------------------------------------------------------------------------
// branch_resolver
//
// Consumer end of the ALU condition-code interface. Holds the {S,Z,C,V} flag
// word and resolves one conditional branch at a time against a flag snapshot
// taken when the request is accepted. A taken branch is followed by a flush
// pulse of FLUSH_CYCLES cycles before the next request is accepted.
//
// Optional feature (compile-time macro BRANCH_RESOLVER_FLAG_BYPASS_EN):
//   defined   - a flag write in the accept cycle is forwarded into the snapshot
//   undefined - the snapshot always uses the pre-update flag register
//
// Ports:
//   clk         clock, rising edge
//   rst         synchronous active-high reset
//   flag_we     load flags_in into the flag register
//   flags_in    {S,Z,C,V} from the ALU
//   br_valid    branch request valid
//   br_ready    resolver can accept a request
//   br_cond     condition select (BE,BLT,BLE,BNE,BCS,BVS,never,always)
//   br_pc       PC of the branch instruction
//   br_disp     signed displacement
//   res_valid   one-cycle result strobe
//   res_taken   branch taken (held between results)
//   res_target  next PC (held between results)
//   flush       squash younger instructions
//   flags_q     current flag register contents
// -----------------------------------------------------------------------------
module branch_resolver #(
    parameter int unsigned FLUSH_CYCLES = 2,
    parameter int unsigned DISP_W       = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flag_we,
    input  logic [3:0]        flags_in,
    input  logic              br_valid,
    output logic              br_ready,
    input  logic [2:0]        br_cond,
    input  logic [15:0]       br_pc,
    input  logic [DISP_W-1:0] br_disp,
    output logic              res_valid,
    output logic              res_taken,
    output logic [15:0]       res_target,
    output logic              flush,
    output logic [3:0]        flags_q
);

    typedef enum logic [1:0] {
        StIdle,
        StResolve,
        StFlush
    } state_e;

    state_e      state_q;
    logic [3:0]  cnt_q;

    logic        accept;
    logic [3:0]  snap_flags;
    logic        cond_true;
    logic [15:0] disp_ext;
    logic [15:0] seq_pc;
    logic [15:0] target;

    // Ready is forced low while reset is asserted so nothing is accepted then.
    assign br_ready = (state_q == StIdle) && !rst;
    assign accept   = br_valid && br_ready;

`ifdef BRANCH_RESOLVER_FLAG_BYPASS_EN
    assign snap_flags = flag_we ? flags_in : flags_q;
`else
    assign snap_flags = flags_q;
`endif

    // Condition evaluated directly against the snapshot; the result is
    // registered at the accept edge so later flag writes cannot disturb it.
    always_comb begin
        cond_true = 1'b0;
        unique case (br_cond)
            3'b000: cond_true = snap_flags[2];                  // BE  : Z
            3'b001: cond_true = snap_flags[3];                  // BLT : S
            3'b010: cond_true = snap_flags[3] | snap_flags[2];  // BLE : S|Z
            3'b011: cond_true = ~snap_flags[2];                 // BNE : !Z
            3'b100: cond_true = snap_flags[1];                  // BCS : C
            3'b101: cond_true = snap_flags[0];                  // BVS : V
            3'b110: cond_true = 1'b0;                           // never
            3'b111: cond_true = 1'b1;                           // always
            default: cond_true = 1'b0;
        endcase
    end

    assign disp_ext = 16'($signed(br_disp));
    assign seq_pc   = br_pc + 16'd1;
    assign target   = cond_true ? (seq_pc + disp_ext) : seq_pc;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            cnt_q      <= 4'd0;
            flags_q    <= 4'b0000;
            res_valid  <= 1'b0;
            res_taken  <= 1'b0;
            res_target <= 16'h0000;
            flush      <= 1'b0;
        end else begin
            if (flag_we) begin
                flags_q <= flags_in;
            end
            res_valid <= 1'b0;

            unique case (state_q)
                StIdle: begin
                    if (accept) begin
                        state_q    <= StResolve;
                        res_valid  <= 1'b1;
                        res_taken  <= cond_true;
                        res_target <= target;
                    end
                end
                StResolve: begin
                    if (res_taken) begin
                        state_q <= StFlush;
                        flush   <= 1'b1;
                        cnt_q   <= 4'(FLUSH_CYCLES);
                    end else begin
                        state_q <= StIdle;
                    end
                end
                StFlush: begin
                    // Count reaching 1 marks the last flush cycle.
                    if (cnt_q <= 4'd1) begin
                        state_q <= StIdle;
                        flush   <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                default: begin
                    state_q <= StIdle;
                    flush   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_branch_resolver.sv
// -----------------------------------------------------------------------------
// tb_branch_resolver
//
// Self-checking bench for branch_resolver: directed scenarios followed by
// randomized branches, all checked against a behavioural model of the flag
// register, condition table and target arithmetic.
// -----------------------------------------------------------------------------
module tb_branch_resolver;

    localparam int unsigned FLUSH_CYCLES = 2;
    localparam int unsigned DISP_W       = 8;

`ifdef BRANCH_RESOLVER_FLAG_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic              flag_we;
    logic [3:0]        flags_in;
    logic              br_valid;
    logic              br_ready;
    logic [2:0]        br_cond;
    logic [15:0]       br_pc;
    logic [DISP_W-1:0] br_disp;
    logic              res_valid;
    logic              res_taken;
    logic [15:0]       res_target;
    logic              flush;
    logic [3:0]        flags_q;

    int checks = 0;
    int errors = 0;

    logic [3:0] model_flags;

    branch_resolver #(
        .FLUSH_CYCLES(FLUSH_CYCLES),
        .DISP_W      (DISP_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .flag_we   (flag_we),
        .flags_in  (flags_in),
        .br_valid  (br_valid),
        .br_ready  (br_ready),
        .br_cond   (br_cond),
        .br_pc     (br_pc),
        .br_disp   (br_disp),
        .res_valid (res_valid),
        .res_taken (res_taken),
        .res_target(res_target),
        .flush     (flush),
        .flags_q   (flags_q)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Step to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic bit model_taken(input logic [2:0] cond, input logic [3:0] f);
        bit s, z, c, v;
        s = f[3]; z = f[2]; c = f[1]; v = f[0];
        case (cond)
            3'd0: return z;
            3'd1: return s;
            3'd2: return s || z;
            3'd3: return !z;
            3'd4: return c;
            3'd5: return v;
            3'd6: return 1'b0;
            default: return 1'b1;
        endcase
    endfunction

    function automatic logic [15:0] model_target(input bit taken, input logic [15:0] pc,
                                                 input logic [DISP_W-1:0] disp);
        int d;
        int t;
        d = int'(disp);
        if (disp[DISP_W-1]) d = d - (1 << DISP_W);
        t = int'(pc) + 1 + (taken ? d : 0);
        return 16'(t & 32'hFFFF);
    endfunction

    task automatic rand_flag_write();
        if ($urandom_range(0, 2) == 0) begin
            flag_we  = 1'b1;
            flags_in = 4'($urandom);
        end
    endtask

    task automatic commit_flag_write(input string tag);
        if (flag_we) model_flags = flags_in;
        flag_we = 1'b0;
        chk(tag, flags_q, model_flags);
    endtask

    task automatic write_flags(input logic [3:0] f);
        flag_we  = 1'b1;
        flags_in = f;
        tick();
        commit_flag_write("flags_write");
    endtask

    // One complete branch: accept, check the result cycle, then walk the busy
    // period counting flush cycles while junk requests and flag writes occur.
    task automatic do_branch(input string tag, input logic [2:0] cond, input logic [15:0] pc,
                             input logic [DISP_W-1:0] disp, input bit fwe,
                             input logic [3:0] fin);
        logic [3:0]  snap;
        bit          exp_taken;
        logic [15:0] exp_target;
        int          exp_wait;
        int          waited;
        int          flushes;

        snap       = (BYPASS && fwe) ? fin : model_flags;
        exp_taken  = model_taken(cond, snap);
        exp_target = model_target(exp_taken, pc, disp);
        exp_wait   = exp_taken ? int'(FLUSH_CYCLES) : 0;

        chk({tag, "_ready_before"}, br_ready, 1'b1);
        br_valid = 1'b1;
        br_cond  = cond;
        br_pc    = pc;
        br_disp  = disp;
        flag_we  = fwe;
        flags_in = fin;
        tick();
        commit_flag_write({tag, "_flags_after_accept"});

        chk({tag, "_res_valid"}, res_valid, 1'b1);
        chk({tag, "_res_taken"}, res_taken, exp_taken);
        chk({tag, "_res_target"}, res_target, exp_target);
        chk({tag, "_flush_t1"}, flush, 1'b0);
        chk({tag, "_ready_t1"}, br_ready, 1'b0);

        // Requester keeps a junk request up; it must be ignored while busy.
        br_cond = 3'($urandom);
        br_pc   = 16'($urandom);
        br_disp = DISP_W'($urandom);
        waited  = 0;
        flushes = 0;
        rand_flag_write();
        tick();
        commit_flag_write({tag, "_flags_t2"});
        while (!br_ready && waited < 40) begin
            chk({tag, "_res_valid_busy"}, res_valid, 1'b0);
            if (flush) flushes++;
            rand_flag_write();
            tick();
            commit_flag_write({tag, "_flags_busy"});
            waited++;
        end
        br_valid = 1'b0;

        chk({tag, "_busy_cycles"}, waited, exp_wait);
        chk({tag, "_flush_cycles"}, flushes, exp_wait);
        chk({tag, "_flush_idle"}, flush, 1'b0);
        chk({tag, "_res_valid_idle"}, res_valid, 1'b0);
        chk({tag, "_taken_hold"}, res_taken, exp_taken);
        chk({tag, "_target_hold"}, res_target, exp_target);
    endtask

    initial begin
        rst      = 1'b1;
        flag_we  = 1'b0;
        flags_in = 4'h0;
        br_valid = 1'b0;
        br_cond  = 3'd0;
        br_pc    = 16'h0;
        br_disp  = '0;
        model_flags = 4'h0;

        // Reset for two cycles.
        tick();
        tick();
        chk("rst_flags", flags_q, 4'h0);
        chk("rst_ready", br_ready, 1'b0);
        chk("rst_res_valid", res_valid, 1'b0);
        chk("rst_res_taken", res_taken, 1'b0);
        chk("rst_res_target", res_target, 16'h0);
        chk("rst_flush", flush, 1'b0);
        rst = 1'b0;
        #1;
        chk("idle_ready", br_ready, 1'b1);
        tick();
        chk("idle_ready_next", br_ready, 1'b1);
        chk("idle_flags", flags_q, 4'h0);

        // BE taken, target 0x0016, two flush cycles.
        write_flags(4'b0100);
        do_branch("be_taken", 3'd0, 16'h0010, 8'h05, 1'b0, 4'h0);

        // BLT not taken with negative displacement.
        write_flags(4'b0000);
        do_branch("blt_nt", 3'd1, 16'h0040, 8'hF0, 1'b0, 4'h0);

        // Always-taken wrap-around.
        do_branch("wrap", 3'd7, 16'hFFFE, 8'h03, 1'b0, 4'h0);

        // Same-cycle flag write on the accept.
        write_flags(4'b0000);
        do_branch("same_cycle", 3'd0, 16'h0100, 8'h10, 1'b1, 4'b0100);
        chk("same_cycle_flags", flags_q, 4'b0100);

        // Reset during the first flush cycle.
        write_flags(4'b1111);
        br_valid = 1'b1;
        br_cond  = 3'd7;
        br_pc    = 16'h0200;
        br_disp  = 8'h04;
        tick();
        br_valid = 1'b0;
        chk("rstfl_res_valid", res_valid, 1'b1);
        tick();
        chk("rstfl_flush_on", flush, 1'b1);
        rst = 1'b1;
        tick();
        model_flags = 4'h0;
        chk("rstfl_flush_off", flush, 1'b0);
        chk("rstfl_flags", flags_q, 4'h0);
        chk("rstfl_res_valid_off", res_valid, 1'b0);
        rst = 1'b0;
        #1;
        chk("rstfl_ready", br_ready, 1'b1);
        tick();
        do_branch("post_rst", 3'd3, 16'h0300, 8'h80, 1'b0, 4'h0);

        // Randomized branches.
        for (int i = 0; i < 60; i++) begin
            logic [15:0] pc;
            if ($urandom_range(0, 1) == 0) write_flags(4'($urandom));
            pc = ($urandom_range(0, 3) == 0) ? (16'hFFF0 | 16'($urandom_range(0, 15)))
                                             : 16'($urandom);
            do_branch("rand", 3'($urandom), pc, DISP_W'($urandom),
                      ($urandom_range(0, 3) == 0), 4'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/branch_resolver.md
Name: branch_resolver

Overview:
- Consumer end of the ALU condition-code interface. Holds the 4-bit flags word {S,Z,C,V} (bit3..bit0) produced by the ALU and resolves conditional branches against it.
- Accepts one branch request at a time via a valid/ready handshake. Reports taken/not-taken and the 16-bit target, then drives a pipeline flush for a fixed number of cycles on taken branches.
- Sits between the ALU/flag writeback and the PC/fetch stage.

Parameters:
- FLUSH_CYCLES, 2, cycles `flush` stays high after a taken branch; legal range 1..15.
- DISP_W, 8, width of the signed branch displacement; legal range 2..16.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous active-high reset.
- flag_we  in  1  load `flags_in` into the flag register this cycle.
- flags_in  in  4  {S,Z,C,V} from the ALU. S is already overflow-corrected (signed less-than).
- br_valid  in  1  branch request valid.
- br_ready  out  1  resolver can accept a request.
- br_cond  in  3  condition select.
- br_pc  in  16  PC of the branch instruction.
- br_disp  in  DISP_W  signed displacement.
- res_valid  out  1  resolution result valid, one-cycle pulse.
- res_taken  out  1  branch taken; meaningful only when `res_valid`=1.
- res_target  out  16  next PC.
- flush  out  1  squash younger instructions.
- flags_q  out  4  current flag register contents.

Behaviour:
- Clock is `clk`. Reset `rst` is synchronous and active-high. Single clock domain.
- Reset values: `flags_q`=0000, `br_ready`=0 during the reset cycle then 1, `res_valid`=0, `res_taken`=0, `res_target`=0000, `flush`=0. State returns to IDLE.
- Reset overrides everything, including mid-RESOLVE or mid-FLUSH. On the edge after `rst`, `flush` and `res_valid` are 0.
- Flag register: on each edge with `flag_we`=1, `flags_q` <= `flags_in`. This applies in every state, independent of branch activity.
- Condition codes for `br_cond`:
  - 000 BE: Z
  - 001 BLT: S
  - 010 BLE: S|Z
  - 011 BNE: !Z
  - 100 BCS: C
  - 101 BVS: V
  - 110 never
  - 111 always
- States:
  - IDLE: `br_ready`=1. On `br_valid`&`br_ready` (accept edge T), capture `br_pc`, `br_disp`, `br_cond` and a flag snapshot; go to RESOLVE.
  - RESOLVE: `br_ready`=0. During cycle T+1, `res_valid`=1 with registered `res_taken` and `res_target`. If taken, go to FLUSH and load the counter with FLUSH_CYCLES. If not taken, go to IDLE.
  - FLUSH: `flush`=1 and `br_ready`=0. The counter decrements each cycle; when it reaches 1, go to IDLE. `flush` is therefore high for exactly FLUSH_CYCLES cycles, T+2 .. T+1+FLUSH_CYCLES.
- Latency: accept to result is 1 cycle. Back-to-back throughput is one branch per 2 cycles when not taken, and per 2+FLUSH_CYCLES cycles when taken.
- Target:
  - Taken: `res_target` = `br_pc` + 1 + sign_extend(`br_disp`), modulo 2^16. Wrap-around is silent, e.g. FFFF+1+0 = 0000.
  - Not taken: `res_target` = `br_pc` + 1, also modulo 2^16.
- Outside RESOLVE, `res_taken` and `res_target` hold their last values and `res_valid`=0.
- `br_valid` while `br_ready`=0 is ignored. The requester holds the request; nothing is queued.
- Flag snapshot: the snapshot taken at the accept edge is used for evaluation. A `flag_we` during RESOLVE or FLUSH updates `flags_q` but does not change the in-flight result.
- Simultaneous `flag_we` and accept in the same cycle: see the optional feature.

Optional Feature:
- Macro: BRANCH_RESOLVER_FLAG_BYPASS_EN.
- Defined: when `flag_we`=1 on the accept cycle, the snapshot takes `flags_in` (the forwarded new flags).
- Undefined: the snapshot always takes `flags_q` (the pre-update value), and the instruction scheduler guarantees one cycle of separation.
- In both cases `flags_q` itself updates normally.

Test Plan:
- Reset then idle:
  - `rst`=1 for 2 cycles -> all outputs at reset values.
  - Next cycle -> `br_ready`=1, `flags_q`=0000.
- BE taken:
  - Stimulus: `flag_we`, `flags_in`=0100; then accept `br_cond`=000, `br_pc`=0010, `br_disp`=05.
  - Required: T+1 `res_valid`=1, `res_taken`=1, `res_target`=0016. `flush`=1 on T+2 and T+3 only. `br_ready` returns to 1 at T+4.
- BLT not taken with negative displacement:
  - Stimulus: `flags_q`=0000; accept `br_cond`=001, `br_pc`=0040, `br_disp`=F0.
  - Required: `res_taken`=0, `res_target`=0041, `flush` never asserted, `br_ready`=1 at T+2.
- Wrap-around:
  - Stimulus: `br_cond`=111, `br_pc`=FFFE, `br_disp`=03.
  - Required: `res_target`=0002, `res_taken`=1.
- Same-cycle flag write:
  - Stimulus: `flags_q`=0000; `flag_we` with `flags_in`=0100 on the accept of `br_cond`=000.
  - Required with the macro: `res_taken`=1. Required without it: `res_taken`=0. In both cases `flags_q`=0100 afterwards.
- Reset during FLUSH:
  - Stimulus: a taken branch; assert `rst` on the first FLUSH cycle.
  - Required: next cycle `flush`=0 and `flags_q`=0000. `br_ready`=1 after `rst` is released, and a new request is accepted normally.
